// File: rtl/connect_net_skid.sv
// Registered valid/ready pipeline stage with a one-entry skid register, placed
// upstream of a pass-through net; also reports occupancy and a wrapping transfer count.
module connect_net_skid #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           count,
  output logic [CNT_WIDTH-1:0] xfer_count
);

  // Encoding doubles as the occupancy value driven on count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] skid;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign count    = state;

  // out_data is the main register; in_ready and out_valid are registered
  // from the next state so no path from out_ready reaches in_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid       <= '0;
      xfer_count <= '0;
    end else begin
      if (out_xfer) begin
        xfer_count <= xfer_count + CNT_WIDTH'(1);
      end
      in_ready <= 1'b1;
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            skid     <= in_data;
            in_ready <= 1'b0;
            state    <= FULL;
          end else if (in_xfer) begin
            out_data <= in_data;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            out_data <= skid;
            state    <= ONE;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= EMPTY;
        end
      endcase
    end
  end

endmodule
